// File: rtl/seq_link_pkg.sv
// Shared definitions for the serial sequence-detection link: FSM encoding
// and default pattern / idle-fill settings.
package seq_link_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int                         DEF_PATTERN_LEN = 4;
    localparam logic [DEF_PATTERN_LEN-1:0] DEF_PATTERN     = 4'b1011;
    localparam logic                       DEF_IDLE_BIT    = 1'b0;

endpackage

// File: rtl/seq_pattern_model.sv
// Reference model of the Moore sequence detector: watches the serial line and
// predicts the detector output one cycle after the final pattern bit.
module seq_pattern_model
    import seq_link_pkg::*;
#(
    parameter int                     PATTERN_LEN = DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = DEF_PATTERN,
    parameter logic                   IDLE_BIT    = DEF_IDLE_BIT,
    parameter int                     COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               serial_bit,
    output logic               expect_detect,
    output logic [COUNT_W-1:0] match_count
);

    localparam int               FILL_W    = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PATTERN_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

    // Only the most recent PATTERN_LEN-1 bits are kept; the live line bit
    // completes the comparison window.
    logic [PATTERN_LEN-2:0] hist;
    logic [FILL_W-1:0]      fill;
    logic [PATTERN_LEN-1:0] window;

    assign window = {hist, serial_bit};

    always_ff @(posedge clock) begin
        if (reset) begin
            hist          <= {(PATTERN_LEN-1){IDLE_BIT}};
            fill          <= '0;
            expect_detect <= 1'b0;
            match_count   <= '0;
        end else begin
            hist          <= window[PATTERN_LEN-2:0];
            expect_detect <= (window == PATTERN) && (fill >= FILL_NEED);
            if (fill != FILL_MAX) begin
                fill <= fill + FILL_ONE;
            end
            if (expect_detect && (match_count != '1)) begin
                match_count <= match_count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/sequence_pattern_tx.sv
// Transmit side of the sequence-detection link: serializes parallel words
// MSB-first and carries a detector reference model for loopback checking.
module sequence_pattern_tx
    import seq_link_pkg::*;
#(
    parameter int                     WORD_W      = 8,
    parameter int                     PATTERN_LEN = DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = DEF_PATTERN,
    parameter logic                   IDLE_BIT    = DEF_IDLE_BIT,
    parameter int                     COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WORD_W-1:0]  data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               sequence_out,
    output logic               bit_valid,
    output logic               busy,
    output logic               expect_detect,
    output logic [COUNT_W-1:0] match_count
);

    localparam int              CNT_W   = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              accept;

    // Handshake: a word transfers on every rising edge where data_valid and
    // data_ready are both high (never on a reset edge). data_ready is also
    // high during the last bit of a word so words can stream with no gap.
    assign data_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && (bit_cnt == '0));
    assign accept     = data_valid && data_ready;
    assign busy       = (state == ST_SHIFT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            sequence_out <= IDLE_BIT;
            bit_valid    <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
        end else if (accept) begin
            state        <= ST_SHIFT;
            sequence_out <= data_in[WORD_W-1];
            bit_valid    <= 1'b1;
            shreg        <= data_in << 1;
            bit_cnt      <= CNT_LAST;
        end else if (state == ST_SHIFT) begin
            if (bit_cnt != '0) begin
                sequence_out <= shreg[WORD_W-1];
                shreg        <= shreg << 1;
                bit_cnt      <= bit_cnt - CNT_ONE;
            end else begin
                state        <= ST_IDLE;
                sequence_out <= IDLE_BIT;
                bit_valid    <= 1'b0;
            end
        end
    end

    seq_pattern_model #(
        .PATTERN_LEN (PATTERN_LEN),
        .PATTERN     (PATTERN),
        .IDLE_BIT    (IDLE_BIT),
        .COUNT_W     (COUNT_W)
    ) u_model (
        .clock         (clock),
        .reset         (reset),
        .serial_bit    (sequence_out),
        .expect_detect (expect_detect),
        .match_count   (match_count)
    );

endmodule

// File: tb/tb_sequence_pattern_tx.sv
// Directed bench for sequence_pattern_tx: a default-width instance plus a
// COUNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_sequence_pattern_tx;

    logic        clock;
    logic        reset;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        data_ready, sequence_out, bit_valid, busy, expect_detect;
    logic [15:0] match_count;
    logic        sat_ready, sat_seq, sat_bv, sat_busy, sat_det;
    logic [1:0]  sat_count;

    int tests_run    = 0;
    int tests_failed = 0;

    sequence_pattern_tx dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .sequence_out  (sequence_out),
        .bit_valid     (bit_valid),
        .busy          (busy),
        .expect_detect (expect_detect),
        .match_count   (match_count)
    );

    sequence_pattern_tx #(.COUNT_W(2)) dut_sat (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (sat_ready),
        .sequence_out  (sat_seq),
        .bit_valid     (sat_bv),
        .busy          (sat_busy),
        .expect_detect (sat_det),
        .match_count   (sat_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        repeat (3) tick();
        tests_run++;
        if ({sequence_out, bit_valid, data_ready, busy, expect_detect} !== 5'b00100) begin
            tests_failed++;
            $display("FAIL reset_flags: got seq/bv/rdy/busy/det=%b required 00100",
                     {sequence_out, bit_valid, data_ready, busy, expect_detect});
        end
        tests_run++;
        if (match_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d required 0", match_count);
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        tick();
        tests_run++;
        if ({bit_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_no_accept: got bv/busy=%b required 00", {bit_valid, busy});
        end
    endtask

    task automatic test_single;
        logic [31:0] seq_v, det_v, bv_v;
        seq_v = '0; det_v = '0; bv_v = '0;
        do_reset();
        send_word(8'hB0);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                tests_run++;
                if ({data_ready, busy} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL single_first_cycle: got rdy/busy=%b required 01", {data_ready, busy});
                end
            end
            seq_v = {seq_v[30:0], sequence_out};
            det_v = {det_v[30:0], expect_detect};
            bv_v  = {bv_v[30:0], bit_valid};
            tick();
        end
        tests_run++;
        if (seq_v[9:0] !== 10'b1011000000) begin
            tests_failed++;
            $display("FAIL single_seq: got %b required 1011000000", seq_v[9:0]);
        end
        tests_run++;
        if (det_v[9:0] !== 10'b0000100000) begin
            tests_failed++;
            $display("FAIL single_detect: got %b required 0000100000", det_v[9:0]);
        end
        tests_run++;
        if (bv_v[9:0] !== 10'b1111111100) begin
            tests_failed++;
            $display("FAIL single_bit_valid: got %b required 1111111100", bv_v[9:0]);
        end
        tests_run++;
        if (match_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d required 1", match_count);
        end
    endtask

    task automatic test_overlap;
        logic [31:0] seq_v, det_v;
        seq_v = '0; det_v = '0;
        do_reset();
        send_word(8'hB6);
        for (int i = 0; i < 10; i++) begin
            seq_v = {seq_v[30:0], sequence_out};
            det_v = {det_v[30:0], expect_detect};
            tick();
        end
        tests_run++;
        if (seq_v[9:0] !== 10'b1011011000) begin
            tests_failed++;
            $display("FAIL overlap_seq: got %b required 1011011000", seq_v[9:0]);
        end
        tests_run++;
        if (det_v[9:0] !== 10'b0000100100) begin
            tests_failed++;
            $display("FAIL overlap_detect: got %b required 0000100100", det_v[9:0]);
        end
        tests_run++;
        if (match_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL overlap_count: got %0d required 2", match_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] seq_v, det_v, bv_v;
        seq_v = '0; det_v = '0; bv_v = '0;
        do_reset();
        send_word(8'h01);
        for (int i = 0; i < 18; i++) begin
            seq_v = {seq_v[30:0], sequence_out};
            det_v = {det_v[30:0], expect_detect};
            bv_v  = {bv_v[30:0], bit_valid};
            if (i == 3) begin
                tests_run++;
                if (data_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_ready_mid: got %b required 0", data_ready);
                end
            end
            if (i == 7) begin
                tests_run++;
                if (data_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_ready_last: got %b required 1", data_ready);
                end
                data_in    = 8'h60;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
                data_in    = 8'h00;
            end
            tick();
        end
        tests_run++;
        if (seq_v[17:0] !== 18'h00580) begin
            tests_failed++;
            $display("FAIL b2b_seq: got %h required 00580", seq_v[17:0]);
        end
        tests_run++;
        if (bv_v[17:0] !== 18'h3FFFC) begin
            tests_failed++;
            $display("FAIL b2b_bit_valid: got %h required 3fffc", bv_v[17:0]);
        end
        tests_run++;
        if (det_v[17:0] !== 18'h00040) begin
            tests_failed++;
            $display("FAIL b2b_detect: got %h required 00040", det_v[17:0]);
        end
        tests_run++;
        if (match_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d required 1", match_count);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [31:0] det_v;
        det_v = '0;
        do_reset();
        send_word(8'hB0);
        tick();
        tick();
        tests_run++;
        if ({sequence_out, bit_valid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midrst_third_bit: got seq/bv=%b required 11", {sequence_out, bit_valid});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({sequence_out, bit_valid, data_ready, busy} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midrst_flags: got seq/bv/rdy/busy=%b required 0010",
                     {sequence_out, bit_valid, data_ready, busy});
        end
        for (int i = 0; i < 8; i++) begin
            det_v = {det_v[30:0], expect_detect};
            tick();
        end
        tests_run++;
        if (det_v[7:0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_detect: got %b required 00000000", det_v[7:0]);
        end
        tests_run++;
        if (match_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d required 0", match_count);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] prev;
        logic       dec_seen;
        dec_seen = 1'b0;
        do_reset();
        prev = sat_count;
        send_word(8'hB6);
        for (int i = 0; i < 10; i++) begin
            if (sat_count < prev) dec_seen = 1'b1;
            prev = sat_count;
            tick();
        end
        tests_run++;
        if (sat_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL sat_after_first: got %0d required 2", sat_count);
        end
        send_word(8'hB6);
        for (int i = 0; i < 10; i++) begin
            if (sat_count < prev) dec_seen = 1'b1;
            prev = sat_count;
            if (i == 5) begin
                tests_run++;
                if (sat_count !== 2'd3) begin
                    tests_failed++;
                    $display("FAIL sat_reach_max: got %0d required 3", sat_count);
                end
            end
            tick();
        end
        tests_run++;
        if (sat_count !== 2'd3) begin
            tests_failed++;
            $display("FAIL sat_hold: got %0d required 3", sat_count);
        end
        tests_run++;
        if (dec_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_no_wrap: got decrease=%b required 0", dec_seen);
        end
        tests_run++;
        if (match_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL sat_wide_count: got %0d required 4", match_count);
        end
        tests_run++;
        if ({sat_ready, sat_seq, sat_bv, sat_busy, sat_det} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL sat_idle_flags: got rdy/seq/bv/busy/det=%b required 10000",
                     {sat_ready, sat_seq, sat_bv, sat_busy, sat_det});
        end
    endtask

    // sequence and final report
    initial begin
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_single();
        test_overlap();
        test_back_to_back();
        test_reset_mid_word();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sequence_pattern_tx.md
Name: sequence_pattern_tx

Overview:
- Transmit side of the serial sequence-detection link: accepts parallel words over a valid/ready handshake and serializes them MSB-first onto a 1-bit line that feeds the Moore sequence detector.
- Also contains a reference model of the detector. It produces `expect_detect`, which is cycle-aligned with the detector output, and a saturating match counter, so self-checking benches and loopback checks can compare against the detector directly.

Parameters:
- WORD_W, 8: width of `data_in`, in bits serialized per word.
- PATTERN, 4'b1011: target bit pattern. MSB is the earliest bit transmitted.
- PATTERN_LEN, 4: width of PATTERN. Must be at least 2 and at most WORD_W.
- IDLE_BIT, 1'b0: level driven on `sequence_out` when no word is in flight.
- COUNT_W, 16: width of `match_count`.

Ports:
- clock  input  1  Single clock. All logic is rising-edge.
- reset  input  1  Synchronous, active-high reset.
- data_in  input  WORD_W  Word to serialize.
- data_valid  input  1  `data_in` is valid.
- data_ready  output  1  Block can accept a word this cycle.
- sequence_out  output  1  Registered serial bit. Connects to the detector's `sequence_in`.
- bit_valid  output  1  `sequence_out` carries a data bit rather than idle fill.
- busy  output  1  State is SHIFT.
- expect_detect  output  1  Registered prediction of the detector output.
- match_count  output  COUNT_W  Count of cycles in which `expect_detect` was high. Saturates.

Behaviour:
- States: IDLE, SHIFT. The state is held in a register; `busy` = (state == SHIFT).
- Reset values: state = IDLE, `sequence_out` = IDLE_BIT, `bit_valid` = 0, `expect_detect` = 0, `match_count` = 0, shift register = 0, bit counter = 0, history = all IDLE_BIT, fill counter = 0.
- Handshake: `data_ready` is combinational.
  - `data_ready` = (state == IDLE) || (state == SHIFT && bit_cnt == 0).
  - A word is accepted on any edge where `data_valid` and `data_ready` are both high.
  - `data_in` is ignored on every other edge.
- Accept edge:
  - `sequence_out` <= `data_in`[WORD_W-1]
  - `bit_valid` <= 1
  - shreg <= `data_in` << 1
  - bit_cnt <= WORD_W-1
  - state <= SHIFT
- Latency: the first bit is visible in the cycle immediately after the accept edge. Each word occupies exactly WORD_W consecutive cycles on `sequence_out`.
- SHIFT with bit_cnt > 0, each edge:
  - `sequence_out` <= shreg MSB
  - shreg <<= 1
  - bit_cnt decrements
- SHIFT with bit_cnt == 0 (last bit on the line):
  - If a word is accepted, it loads as in the accept edge. There are no gap cycles and `bit_valid` stays high.
  - Otherwise: `sequence_out` <= IDLE_BIT, `bit_valid` <= 0, state <= IDLE.
- Detector model:
  - Every edge: hist[PATTERN_LEN-1:0] <= {hist[PATTERN_LEN-2:0], `sequence_out`}. This includes idle bits, because the detector sees them too.
  - fill counter increments, saturating at PATTERN_LEN.
  - `expect_detect` <= ({hist[PATTERN_LEN-2:0], `sequence_out`} == PATTERN) && (fill >= PATTERN_LEN-1).
  - Result: `expect_detect` rises in the cycle after the edge that samples the final pattern bit, which matches the Moore detector timing.
  - Overlapping matches are detected.
- Counter:
  - `match_count` increments on each edge where `expect_detect` is 1.
  - It holds at 2^COUNT_W-1; it never wraps.
- Reset mid-word:
  - The in-flight word is discarded.
  - All registers return to their reset values on that edge.
  - `data_ready` is high in the next cycle.
- `data_valid` asserted during reset: ignored. No word is accepted on a reset edge.

Decomposition:
- Shared package `seq_link_pkg`: state encoding constants (ST_IDLE, ST_SHIFT), default PATTERN/PATTERN_LEN, and IDLE_BIT.
- One sub-module, `seq_pattern_model`. It contains the history shift, fill counter, `expect_detect` and the saturating `match_count`.
- The top level holds the handshake FSM and serializer.

Test Plan:
- Reset: hold `reset`=1 for 3 cycles with `data_valid`=1 and `data_in`=8'hFF -> `sequence_out`=0, `bit_valid`=0, `data_ready`=1, `match_count`=0, and no word is taken.
- Single word: send 8'hB0 with the accept edge at t0 -> `sequence_out` = 1,0,1,1,0,0,0,0 in cycles t0..t7 -> `expect_detect` is a single 1-cycle pulse after edge t4 -> `match_count`=1 -> `bit_valid` drops after edge t8.
- Overlap: send 8'hB6 (10110110) -> two `expect_detect` pulses, 3 cycles apart -> `match_count`=2.
- Back-to-back across a word boundary:
  - Stimulus: 8'h01, then 8'h60 presented during the last-bit cycle.
  - `data_ready` is high in that cycle.
  - `bit_valid` stays high for 16 continuous cycles.
  - Exactly one pulse, from the boundary-spanning 1011.
- Reset mid-word: assert `reset` during the 3rd bit of 8'hB0 -> `sequence_out`=0 and `bit_valid`=0 the next cycle -> no `expect_detect` pulse -> `match_count`=0.
- Saturation: with COUNT_W=2, send 8'hB6 twice -> `match_count` goes 1, 2, 3, 3 and never wraps to 0.
